// File: rtl/lbm_field_reader.sv
// Sweeps every lattice cell, reads p/ux/uy from the field memories and streams
// them as three tagged words per cell over a valid/ready handshake.
module lbm_field_reader #(
    parameter int GRID_DIM      = 16*16,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         start,
    input  logic                         abort,
    output logic                         mem_rd_en,
    output logic [ADDRESS_WIDTH-1:0]     mem_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] p_mem_data_out,
    input  logic signed [DATA_WIDTH-1:0] ux_mem_data_out,
    input  logic signed [DATA_WIDTH-1:0] uy_mem_data_out,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [1:0]                   out_field,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    // state   | meaning
    // IDLE    | waiting for start
    // READ    | read strobe for the current cell
    // LATCH   | memory words arrive, captured at end of cycle
    // SEND_P  | streaming pressure word
    // SEND_UX | streaming x-velocity word
    // SEND_UY | streaming y-velocity word, advances cell or finishes
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LATCH   = 3'd2,
        SEND_P  = 3'd3,
        SEND_UX = 3'd4,
        SEND_UY = 3'd5
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(GRID_DIM - 1);

    state_t                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       index_q, index_d;
    logic signed [DATA_WIDTH-1:0]   p_q, p_d;
    logic signed [DATA_WIDTH-1:0]   ux_q, ux_d;
    logic signed [DATA_WIDTH-1:0]   uy_q, uy_d;
    logic                           done_q, done_d;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            index_q <= '0;
            p_q     <= '0;
            ux_q    <= '0;
            uy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            p_q     <= p_d;
            ux_q    <= ux_d;
            uy_q    <= uy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        p_d       = p_q;
        ux_d      = ux_q;
        uy_d      = uy_q;
        done_d    = 1'b0;
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_field = 2'd0;
        out_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = READ;
                    index_d = '0;
                end
            end
            READ: begin
                mem_rd_en = 1'b1;
                state_d   = LATCH;
            end
            LATCH: begin
                p_d     = p_mem_data_out;
                ux_d    = ux_mem_data_out;
                uy_d    = uy_mem_data_out;
                state_d = SEND_P;
            end
            SEND_P: begin
                out_valid = 1'b1;
                out_data  = p_q;
                out_field = 2'd0;
                if (out_ready) state_d = SEND_UX;
            end
            SEND_UX: begin
                out_valid = 1'b1;
                out_data  = ux_q;
                out_field = 2'd1;
                if (out_ready) state_d = SEND_UY;
            end
            SEND_UY: begin
                out_valid = 1'b1;
                out_data  = uy_q;
                out_field = 2'd2;
                out_last  = (index_q == LAST_IDX);
                if (out_ready) begin
                    // Final cell finishes without touching index so it never wraps.
                    if (index_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + ADDRESS_WIDTH'(1);
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            index_d = index_q;
            done_d  = 1'b0;
        end
    end

    assign mem_rd_addr = index_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: doc/lbm_field_reader.md
LBM_FIELD_READER -- requirements
Module: lbm_field_reader

Interface
REQ-001 Parameter GRID_DIM, default 16*16, is the number of lattice cells to sweep.
REQ-002 Parameter DATA_WIDTH, default 32, is the width of each macroscopic field word.
REQ-003 Parameter ADDRESS_WIDTH, default $clog2(GRID_DIM), is the cell address width.
REQ-004 CLOCK_50  in  1  sole clock; all logic rising-edge.
REQ-005 RESET  in  1  one clock; reset is synchronous and active-high.
REQ-006 start  in  1  single-cycle request to begin one full field sweep.
REQ-007 abort  in  1  synchronous sweep cancel.
REQ-008 mem_rd_en  out  1  read strobe to the p/ux/uy field memories.
REQ-009 mem_rd_addr  out  ADDRESS_WIDTH  cell address for the read.
REQ-010 p_mem_data_out  in  DATA_WIDTH  signed pressure word, valid 1 cycle after mem_rd_en.
REQ-011 ux_mem_data_out  in  DATA_WIDTH  signed x-velocity word, same timing.
REQ-012 uy_mem_data_out  in  DATA_WIDTH  signed y-velocity word, same timing.
REQ-013 out_data  out  DATA_WIDTH  streamed field word.
REQ-014 out_field  out  2  tag: 0=p, 1=ux, 2=uy; 3 never driven.
REQ-015 out_valid  out  1  out_data/out_field/out_last valid.
REQ-016 out_ready  in  1  sink accepts the word when out_valid&&out_ready.
REQ-017 out_last  out  1  marks the uy word of cell GRID_DIM-1.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse on sweep completion.

Function
REQ-020 The FSM SHALL have states IDLE, READ, LATCH, SEND_P, SEND_UX, SEND_UY.
REQ-021 IDLE SHALL go to READ on start, with the cell index cleared to 0; start SHALL be ignored in all other states.
REQ-022 READ SHALL assert mem_rd_en=1 with mem_rd_addr=index for exactly one cycle, then go to LATCH.
REQ-023 LATCH SHALL capture all three memory words into internal registers, then go to SEND_P.
REQ-024 SEND_P, SEND_UX and SEND_UY SHALL each hold out_valid=1 with the matching latched word and tag, and SHALL advance only on a handshake.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_field and out_last SHALL remain stable.
REQ-026 A SEND_UY handshake with index<GRID_DIM-1 SHALL increment index and go to READ.
REQ-027 A SEND_UY handshake with index==GRID_DIM-1 SHALL go to IDLE and assert done in the following cycle; index SHALL NOT wrap or increment.
REQ-028 out_last SHALL be 1 only in SEND_UY when index==GRID_DIM-1.
REQ-029 Words SHALL pass through unmodified: signed, no rescaling, no saturation.
REQ-030 With out_ready held at 1, each cell SHALL take exactly 5 cycles (READ, LATCH, 3 sends).
REQ-031 mem_rd_en SHALL be 0 outside READ; mem_rd_addr SHALL hold the current index at all times.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and drop out_valid; no done pulse is generated. abort has priority over a simultaneous handshake.
REQ-033 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL leave the block in IDLE.
REQ-034 done and start in the same cycle SHALL begin a new sweep, because done is registered and the FSM is already in IDLE.

Reset
REQ-035 RESET=1 at a clock edge SHALL force IDLE, index=0, and mem_rd_en, out_valid, out_last, busy and done all 0; out_data=0; out_field=0.
REQ-036 RESET mid-sweep SHALL discard the latched cell with no done pulse; RESET SHALL take priority over start and abort.

Verification
REQ-037 GRID_DIM=4, out_ready=1, memories p=0x0100_0000*addr, ux=-addr, uy=addr+0x10, pulse start -> 12 words in order p,ux,uy per cell 0..3; out_last only on word 12 (uy=0x13); done exactly 20 cycles after the first READ cycle.
REQ-038 Toggle out_ready 1/0 every cycle -> same 12-word sequence; no word dropped or duplicated; outputs stable during stalls.
REQ-039 Hold out_ready=0 for 50 cycles in SEND_UX of cell 2 -> out_data=-2 and out_field=1 held all 50 cycles; sequence resumes correctly afterwards.
REQ-040 Assert abort in SEND_UY of cell 1 together with out_ready=1 -> out_valid=0 the next cycle, busy=0, no done; a new start restarts at cell 0.
REQ-041 Assert RESET in LATCH of cell 3 -> all outputs at reset values next cycle; a following start produces the full 12-word sweep.
REQ-042 Pulse start while busy -> ignored; only one sweep and one done pulse.
